uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Transmit-side buffer placed directly upstream of the UART transmitter. Register-interface writes
//  are queued here and presented in first-word-fall-through form to the transmitter's
//  data_valid/data_in/data_ready handshake. Also provides level, status and a low-watermark flag
//  for software.
// PARAMETERS
//  DEPTH      16  entries; power of two, >= 2
//  DATA_W      8  character width; matches transmitter data_in
//  LOW_WM      2  tx_low asserts when level <= LOW_WM; range 0..DEPTH-1
// PORTS
//  clk        in   1            single clock domain
//  rst        in   1            synchronous, active-high reset
//  flush      in   1            synchronous clear of contents
//  wr_en      in   1            push request (register write to TX data)
//  wr_data    in   DATA_W       push data
//  wr_ready   out  1            = !full
//  data_valid out  1            to transmitter: head entry present (= !empty)
//  data_in    out  DATA_W       to transmitter: head entry (mem[rd_ptr])
//  data_ready in   1            from transmitter: idle and able to accept
//  level      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  full       out  1            level == DEPTH
//  empty      out  1            level == 0
//  tx_low     out  1            level <= LOW_WM (level-sensitive interrupt source)
//  overflow   out  1            sticky: push attempted while full
//  ovf_clr    in   1            clears overflow
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, level=0, overflow=0.
//    Outputs: empty=1, full=0, data_valid=0, wr_ready=1, tx_low=1.
//    Memory contents are not reset; data_in is don't-care while data_valid=0.
//  - push = wr_en && !full. Write mem[wr_ptr]; wr_ptr increments modulo DEPTH.
//  - pop = data_valid && data_ready. rd_ptr increments modulo DEPTH.
//    A pop coincides with the transmitter latching data_in in its idle state.
//  - Latency: a push into an empty FIFO makes data_valid=1 on the next cycle, with data_in = that
//    word. data_in is a combinational read of mem[rd_ptr].
//  - level next = level + push - pop.
//    - Simultaneous push and pop at 0 < level < DEPTH: level unchanged, both pointers advance.
//  - Full: wr_ready=0. A push while full is dropped and sets overflow. This holds even if a pop
//    occurs in the same cycle (no pass-through).
//  - Empty: data_valid=0, so no pop. A push in the same cycle is accepted and is visible next cycle.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. full/empty derive from level, not from
//    pointer compare.
//  - flush: pointers and level go to 0 the next cycle. It overrides push and pop in the same cycle,
//    so the concurrent wr_en data is discarded.
//    - overflow is NOT cleared by flush.
//    - The transmitter may already hold a latched word; flush does not affect it.
//  - overflow priority: rst > set (dropped push) > ovf_clr. Set and clear in the same cycle leaves
//    overflow=1.
//  - full, empty, data_valid, wr_ready and tx_low are combinational decodes of the registered level.
// STRUCTURE
//  - Shared package uart_pkg: UART_DATA_W=8 and UART_TX_FIFO_DEPTH=16, used by uart_tx_fifo, the
//    receive-side FIFO and the register block.
//  - One sub-module: uart_fifo_mem, a DEPTH x DATA_W register array with one write port and an
//    async read port. The receive FIFO reuses it.
//  - Pointer, level and flag logic are a single always_ff block in this module; no separate FSM.
// TESTING
//  1. Reset then idle, data_ready=1
//     -> empty=1, data_valid=0, level=0, tx_low=1, wr_ready=1; no pop ever occurs.
//  2. Push 0x41, 0x42, 0x43 with data_ready=0, then hold data_ready=1
//     -> data_in order 0x41, 0x42, 0x43; level 3->2->1->0; data_valid drops after the third pop.
//  3. Push 16 words (0x00..0x0F), then push 0xFF while full
//     -> full=1, wr_ready=0, overflow=1, level=16.
//     Drain all 16 -> 0x00..0x0F in order; 0xFF never appears.
//  4. At level=5, push and pop in the same cycle for 20 cycles
//     -> level stays 5, pointers wrap, output order preserved.
//  5. At level=8, assert flush with wr_en=1 and data_ready=1
//     -> next cycle level=0, empty=1, no pop counted; prior overflow state unchanged.
//  6. Watermark sweep with LOW_WM=2, pushing from empty
//     -> tx_low=1 at levels 0..2, 0 at level 3; re-asserts on draining back to 2.
//     Also: overflow set together with ovf_clr -> overflow=1; ovf_clr alone -> 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths, depths and sizing helper
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_TX_FIFO_DEPTH = 16;
  localparam int UART_TX_LOW_WM     = 2;

  // Occupancy counters need one extra bit so that "completely full" is representable.
  function automatic int uart_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x DATA_W register array, one write port, async read port
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_TX_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word-fall-through transmit buffer feeding the UART transmitter
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_TX_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W,
  parameter int LOW_WM = UART_TX_LOW_WM,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = uart_level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_in,
  input  logic              data_ready,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty,
  output logic              tx_low,
  output logic              overflow,
  input  logic              ovf_clr
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // All status flags decode the registered level, so they never glitch with inputs.
  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign wr_ready   = !full;
  assign data_valid = !empty;
  assign tx_low     = (level <= LW'(LOW_WM));

  // A push while full is dropped even if the transmitter pops in the same cycle.
  assign push = wr_en && !full;
  assign pop  = data_valid && data_ready;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (data_in)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
      // Setting wins over clearing so a drop in the clear cycle is never lost.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed vector table plus corner sequences for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       data_valid;
  logic [7:0] data_in;
  logic       data_ready;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       tx_low;
  logic       overflow;
  logic       ovf_clr;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       fl;
    logic       we;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    int         lvl;
    logic       low;
    logic [7:0] head;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH  (16),
    .DATA_W (8),
    .LOW_WM (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .data_valid (data_valid),
    .data_in    (data_in),
    .data_ready (data_ready),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .tx_low     (tx_low),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  function automatic vec_t v(input logic fl, input logic we, input logic [7:0] d,
                             input logic rdy, input logic clr, input int lvl,
                             input logic low, input logic [7:0] head);
    vec_t r;
    r.fl = fl; r.we = we; r.d = d; r.rdy = rdy; r.clr = clr;
    r.lvl = lvl; r.low = low; r.head = head;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic fl, input logic we, input logic [7:0] d,
                       input logic rdy, input logic clr);
    flush = fl; wr_en = we; wr_data = d; data_ready = rdy; ovf_clr = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_level(input string tag, input int lvl, input logic low);
    chk({tag, " level"}, int'(level), lvl);
    chk({tag, " empty"}, int'(empty), int'(lvl == 0));
    chk({tag, " full"}, int'(full), int'(lvl == 16));
    chk({tag, " wr_ready"}, int'(wr_ready), int'(lvl != 16));
    chk({tag, " data_valid"}, int'(data_valid), int'(lvl != 0));
    chk({tag, " tx_low"}, int'(tx_low), int'(low));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 8'h00, 1, 0);
    tick;
    tick;
    chk_level("reset", 0, 1);
    chk("reset overflow", int'(overflow), 0);
    rst = 1'b0;

    // idle with ready high, three-word ordered drain, push into empty with ready, watermark sweep
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 8'h00));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 8'h00));
    vecs.push_back(v(0, 1, 8'h41, 0, 0, 1, 1, 8'h41));
    vecs.push_back(v(0, 1, 8'h42, 0, 0, 2, 1, 8'h41));
    vecs.push_back(v(0, 1, 8'h43, 0, 0, 3, 0, 8'h41));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 2, 1, 8'h42));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 1, 1, 8'h43));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 8'h00));
    vecs.push_back(v(0, 1, 8'h55, 1, 0, 1, 1, 8'h55));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 8'h00));
    vecs.push_back(v(0, 1, 8'h10, 0, 0, 1, 1, 8'h10));
    vecs.push_back(v(0, 1, 8'h11, 0, 0, 2, 1, 8'h10));
    vecs.push_back(v(0, 1, 8'h12, 0, 0, 3, 0, 8'h10));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 2, 1, 8'h11));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 1, 1, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 8'h00));

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].we, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      tick;
      chk_level($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].low);
      chk($sformatf("vec%0d overflow", i), int'(overflow), 0);
      if (vecs[i].lvl != 0) chk($sformatf("vec%0d data_in", i), int'(data_in), int'(vecs[i].head));
    end

    // fill to full, dropped pushes set overflow (also when ovf_clr is high)
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'(i), 0, 0);
      tick;
    end
    chk_level("fill16", 16, 0);
    drive(0, 1, 8'hFF, 0, 1);
    tick;
    chk_level("drop+clr", 16, 0);
    chk("drop+clr overflow", int'(overflow), 1);
    drive(0, 1, 8'hFF, 0, 0);
    tick;
    chk("drop overflow", int'(overflow), 1);
    chk_level("drop", 16, 0);

    // push while full coinciding with a pop is still dropped
    drive(0, 1, 8'hEE, 1, 0);
    chk("drain0 data_in", int'(data_in), 0);
    tick;
    chk_level("full push+pop", 15, 0);
    for (int i = 1; i < 16; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      chk($sformatf("drain%0d data_in", i), int'(data_in), i);
      chk($sformatf("drain%0d valid", i), int'(data_valid), 1);
      tick;
    end
    chk_level("drained", 0, 1);

    // steady push+pop at level 5 for 20 cycles, across pointer wrap
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'(8'h20 + i), 0, 0);
      tick;
    end
    chk_level("lvl5", 5, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 8'(8'h25 + i), 1, 0);
      chk($sformatf("pp%0d data_in", i), int'(data_in), 8'h20 + i);
      tick;
      chk($sformatf("pp%0d level", i), int'(level), 5);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      chk($sformatf("pptail%0d data_in", i), int'(data_in), 8'h34 + i);
      tick;
    end
    chk_level("pp drained", 0, 1);

    // flush at level 8 with concurrent push and ready; overflow stays set
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'(8'h60 + i), 0, 0);
      tick;
    end
    chk_level("lvl8", 8, 0);
    drive(1, 1, 8'h99, 1, 0);
    tick;
    chk_level("flush", 0, 1);
    chk("flush overflow", int'(overflow), 1);
    drive(0, 0, 8'h00, 0, 0);
    tick;
    chk_level("post flush", 0, 1);
    drive(0, 1, 8'h77, 0, 0);
    tick;
    chk_level("post flush push", 1, 1);
    chk("post flush data_in", int'(data_in), 8'h77);
    drive(0, 0, 8'h00, 0, 1);
    tick;
    chk("ovf_clr overflow", int'(overflow), 0);
    drive(0, 0, 8'h00, 1, 0);
    tick;
    chk_level("final", 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
